// File: rtl/prog_bank_sched.sv
// Ping-pong program memory with a scheduled bank swap and interpreter start pulse.
// The host fills the shadow bank while the interpreter reads the active one.
module prog_bank_sched #(
  parameter int ADR_W     = 8,
  parameter int START_LEN = 4,
  parameter int TMO       = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_we,
  input  logic [ADR_W-1:0] host_adr,
  input  logic [7:0]       host_data,
  input  logic             host_commit,
  input  logic             t_immediate,
  input  logic [31:0]      t_start,
  input  logic [31:0]      usec_now,
  input  logic [ADR_W-1:0] rd_adr,
  output logic [7:0]       rd_data,
  input  logic             prog_end,
  output logic             start,
  output logic             active_bank,
  output logic             host_busy,
  output logic [7:0]       run_cnt,
  output logic [1:0]       err
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_WAIT_T = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [3:0]  SLEN    = 4'(START_LEN);
  localparam logic [19:0] WDT_MAX = 20'(TMO - 1);

  logic [2:0]  state_q, state_d;
  logic        active_bank_q, active_bank_d;
  logic [7:0]  run_cnt_q, run_cnt_d;
  logic [1:0]  err_q, err_d;
  logic        start_q, start_d;
  logic        pend_q, pend_d;
  logic        t_imm_q, t_imm_d;
  logic [31:0] t_start_q, t_start_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] wdt_q, wdt_d;
  logic        pe_q;

  logic [7:0] mem0 [0:(2**ADR_W)-1];
  logic [7:0] mem1 [0:(2**ADR_W)-1];

  logic        busy, we_ok, commit_ok, pe_rise, time_ok;
  logic [31:0] t_diff;

  assign busy      = (state_q == S_ARMED) || (state_q == S_WAIT_T) || (state_q == S_START);
  assign we_ok     = host_we & ~busy;
  assign commit_ok = host_commit & ~busy & ~pend_q;
  assign pe_rise   = prog_end & ~pe_q;
  // Wrap-safe time compare: sign of the modular difference.
  assign t_diff    = usec_now - t_start_q;
  assign time_ok   = t_imm_q | ~t_diff[31];

  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    run_cnt_d     = run_cnt_q;
    err_d         = err_q;
    start_d       = start_q;
    pend_d        = pend_q;
    t_imm_d       = t_imm_q;
    t_start_d     = t_start_q;
    cnt_d         = cnt_q;
    wdt_d         = wdt_q;
    err_d[0] = err_q[0] | (busy & (host_we | host_commit)) | (host_commit & pend_q);
    if (commit_ok) begin
      t_start_d = t_start;
      t_imm_d   = t_immediate;
    end
    case (state_q)
      S_IDLE:   if (commit_ok) state_d = S_ARMED;
      S_ARMED:  state_d = S_WAIT_T;
      S_WAIT_T: if (time_ok) begin
        state_d       = S_START;
        active_bank_d = ~active_bank_q;
        run_cnt_d     = run_cnt_q + 8'd1;
        cnt_d         = 4'd0;
        start_d       = 1'b0;
      end
      // First START cycle keeps start low so the pulse always follows a low cycle.
      S_START: if (cnt_q == SLEN) begin
        state_d = S_RUN;
        start_d = 1'b0;
        wdt_d   = 20'd0;
      end else begin
        start_d = 1'b1;
        cnt_d   = cnt_q + 4'd1;
      end
      S_RUN: if (pe_rise) begin
        state_d = (pend_q | commit_ok) ? S_ARMED : S_IDLE;
        pend_d  = 1'b0;
      end else if (wdt_q == WDT_MAX) begin
        state_d  = S_IDLE;
        err_d[1] = 1'b1;
        pend_d   = 1'b0;
      end else begin
        wdt_d = wdt_q + 20'd1;
        if (commit_ok) pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      active_bank_q <= 1'b0;
      run_cnt_q     <= 8'd0;
      err_q         <= 2'd0;
      start_q       <= 1'b0;
      pend_q        <= 1'b0;
      t_imm_q       <= 1'b0;
      t_start_q     <= 32'd0;
      cnt_q         <= 4'd0;
      wdt_q         <= 20'd0;
      pe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      run_cnt_q     <= run_cnt_d;
      err_q         <= err_d;
      start_q       <= start_d;
      pend_q        <= pend_d;
      t_imm_q       <= t_imm_d;
      t_start_q     <= t_start_d;
      cnt_q         <= cnt_d;
      wdt_q         <= wdt_d;
      pe_q          <= prog_end;
    end
  end

  always_ff @(posedge clk) begin
    if (we_ok) begin
      if (active_bank_q) mem0[host_adr] <= host_data;
      else               mem1[host_adr] <= host_data;
    end
  end

  assign rd_data     = active_bank_q ? mem1[rd_adr] : mem0[rd_adr];
  assign start       = start_q;
  assign active_bank = active_bank_q;
  assign host_busy   = busy;
  assign run_cnt     = run_cnt_q;
  assign err         = err_q;
endmodule

// File: tb/tb_prog_bank_sched.sv
// Directed bench for prog_bank_sched: bank swap, timed start, wrap, pending commit, errors, reset.
module tb_prog_bank_sched;
  localparam int ADR_W = 8;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             host_we, host_commit, t_immediate, prog_end;
  logic [ADR_W-1:0] host_adr, rd_adr;
  logic [7:0]       host_data, rd_data, run_cnt;
  logic [31:0]      t_start, usec_now;
  logic             start, active_bank, host_busy;
  logic [1:0]       err;
  int n_cmp = 0;
  int n_err = 0;

  prog_bank_sched #(.ADR_W(ADR_W), .START_LEN(4), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .host_we(host_we), .host_adr(host_adr), .host_data(host_data),
    .host_commit(host_commit), .t_immediate(t_immediate), .t_start(t_start), .usec_now(usec_now),
    .rd_adr(rd_adr), .rd_data(rd_data), .prog_end(prog_end), .start(start),
    .active_bank(active_bank), .host_busy(host_busy), .run_cnt(run_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADR_W-1:0] a, input logic [7:0] d);
    host_we = 1'b1; host_adr = a; host_data = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic pulse_end();
    prog_end = 1'b1;
    @(negedge clk);
    prog_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_commit(input logic imm, input logic [31:0] ts);
    host_commit = 1'b1; t_immediate = imm; t_start = ts;
  endtask

  // Counts negedges from the trigger until start is seen high; optionally measures pulse width.
  task automatic wait_start(input bit inc, input int exp_wait, input bit do_w, input string tag);
    int n; bit busy_ok; int w;
    n = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      host_commit = 1'b0; prog_end = 1'b0;
      if (!start && !host_busy) busy_ok = 1'b0;
      if (inc) usec_now = usec_now + 32'd1;
    end while (!start && n < 200);
    chk({tag, "_wait"}, n, exp_wait);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    if (do_w) begin
      w = 1;
      while (start && w < 20) begin
        @(negedge clk);
        if (start) w++;
      end
      chk({tag, "_width"}, w, 4);
    end
  endtask

  initial begin
    rst_n = 1'b0; host_we = 1'b0; host_commit = 1'b0; t_immediate = 1'b0; prog_end = 1'b0;
    host_adr = '0; host_data = '0; rd_adr = '0; t_start = '0; usec_now = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_bank", active_bank, 0);
    chk("rst_busy", host_busy, 0);
    chk("rst_runcnt", run_cnt, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: load bank1, immediate commit
    wr(8'd0, 8'h30); wr(8'd1, 8'h05); wr(8'd2, 8'hFE);
    set_commit(1'b1, 32'd0);
    wait_start(1'b0, 4, 1'b1, "t1");
    chk("t1_bank", active_bank, 1);
    chk("t1_runcnt", run_cnt, 1);
    chk("t1_busy_run", host_busy, 0);
    rd_adr = 8'd1; #1 chk("t1_rd1", rd_data, 8'h05);
    rd_adr = 8'd0; #1 chk("t1_rd0", rd_data, 8'h30);
    rd_adr = 8'd2; #1 chk("t1_rd2", rd_data, 8'hFE);

    // 2: timed start at 1000 from 990
    pulse_end();
    chk("t2_idle", host_busy, 0);
    usec_now = 32'd990;
    set_commit(1'b0, 32'd1000);
    wait_start(1'b1, 12, 1'b1, "t2");
    chk("t2_runcnt", run_cnt, 2);

    // 3: wrap-around target, then an already-past target
    pulse_end();
    usec_now = 32'hFFFF_FFF0;
    set_commit(1'b0, 32'h0000_0005);
    wait_start(1'b1, 23, 1'b1, "t3a");
    pulse_end();
    usec_now = 32'h0000_0010;
    set_commit(1'b0, 32'hFFFF_FF00);
    wait_start(1'b0, 4, 1'b1, "t3b");
    chk("t3_bank", active_bank, 0);
    chk("t3_runcnt", run_cnt, 4);

    // 4: load shadow during RUN, write+commit same cycle, swap on prog_end
    wr(8'd0, 8'hA1);
    host_we = 1'b1; host_adr = 8'd1; host_data = 8'hB2; set_commit(1'b1, 32'd0);
    @(negedge clk);
    host_we = 1'b0; host_commit = 1'b0;
    chk("t4_busy", host_busy, 0);
    chk("t4_err", err, 0);
    prog_end = 1'b1;
    wait_start(1'b0, 4, 1'b1, "t4");
    chk("t4_bank", active_bank, 1);
    chk("t4_runcnt", run_cnt, 5);
    rd_adr = 8'd0; #1 chk("t4_rd0", rd_data, 8'hA1);
    rd_adr = 8'd1; #1 chk("t4_rd1", rd_data, 8'hB2);
    rd_adr = 8'd2; #1 chk("t4_rd2", rd_data, 8'hFE);

    // 5: write while busy is dropped, then watchdog
    pulse_end();
    wr(8'd0, 8'h11);
    usec_now = 32'd100;
    set_commit(1'b0, 32'd100000);
    @(negedge clk); host_commit = 1'b0;
    @(negedge clk);
    chk("t5_busy_wait", host_busy, 1);
    host_we = 1'b1; host_adr = 8'd0; host_data = 8'h55;
    @(negedge clk);
    host_we = 1'b0;
    chk("t5_err0", err, 2'b01);
    usec_now = 32'd100000;
    wait_start(1'b0, 2, 1'b1, "t5rel");
    chk("t5_bank", active_bank, 0);
    chk("t5_runcnt", run_cnt, 6);
    rd_adr = 8'd0; #1 chk("t5_rd0", rd_data, 8'h11);
    repeat (TMO - 1) @(negedge clk);
    chk("t5_pre_tmo", err, 2'b01);
    @(negedge clk);
    chk("t5_tmo", err, 2'b11);
    chk("t5_tmo_bank", active_bank, 0);

    // 6: immediate start out of IDLE, then async reset while start is high
    set_commit(1'b1, 32'd0);
    wait_start(1'b0, 4, 1'b0, "t6");
    chk("t6_start_hi", start, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_start", start, 0);
    chk("t6_bank", active_bank, 0);
    chk("t6_runcnt", run_cnt, 0);
    chk("t6_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle", host_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
